// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the scan sequencing controller: state encoding,
// default counter widths and a small state-classification helper.
package scan_ctrl_pkg;

  localparam int unsigned REV_W_DEF = 16;
  localparam int unsigned TMO_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ZERO = 3'd1,
    ST_ACQ       = 3'd2,
    ST_DONE      = 3'd3,
    ST_ERR       = 3'd4
  } scan_state_e;

  // The watchdog only runs while a scan is waiting for or consuming zero pulses.
  function automatic logic is_active(input scan_state_e st);
    return (st == ST_WAIT_ZERO) || (st == ST_ACQ);
  endfunction

endpackage

// File: rtl/scan_wdog_cnt.sv
// Inter-pulse watchdog: counts enabled cycles since the last clear and
// flags expiry on the cycle whose edge reaches the limit (limit 0 = off).
module scan_wdog_cnt
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned TMO_W = TMO_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [TMO_W-1:0] limit_i,
  output logic             expire_o
);

  localparam logic [TMO_W-1:0] CNT_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  // Next count: clear wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Not masked by clear: a timeout must beat a zero pulse in the same cycle.
  assign expire_o = enable_i && (limit_i != '0) && (cnt_q >= (limit_i - CNT_ONE));

endmodule

// File: rtl/scan_seq_ctrl.sv
// Scan sequencing FSM: waits for the encoder zero, acquires a configured
// number of revolutions and reports completion, abort or watchdog timeout.
module scan_seq_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter real         TCQ   = 0.1,
  parameter int unsigned REV_W = REV_W_DEF,
  parameter int unsigned TMO_W = TMO_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             encode_zero_flag_i,
  input  logic             scan_start_flag_i,
  input  logic             scan_test_flag_i,
  input  logic [REV_W-1:0] cfg_rev_num_i,
  input  logic [TMO_W-1:0] cfg_timeout_i,
  output logic             acq_en_o,
  output logic             rev_start_o,
  output logic [REV_W-1:0] rev_cnt_o,
  output logic             test_mode_o,
  output logic             busy_o,
  output logic             scan_done_o,
  output logic             scan_abort_o,
  output logic             timeout_err_o
);

  localparam logic [REV_W-1:0] REV_ONE = {{(REV_W-1){1'b0}}, 1'b1};

  scan_state_e      state_q;
  logic             start_dly_q;
  logic [REV_W-1:0] rev_num_q;
  logic [TMO_W-1:0] tmo_q;
  logic             acq_en_q;
  logic             rev_start_q;
  logic [REV_W-1:0] rev_cnt_q;
  logic             test_mode_q;
  logic             busy_q;
  logic             scan_done_q;
  logic             scan_abort_q;
  logic             timeout_err_q;

  logic start_edge_s;
  logic last_rev_s;
  logic wd_en_s;
  logic wd_clear_s;
  logic wd_expire_s;

  assign start_edge_s = scan_start_flag_i & ~start_dly_q;

  // Watchdog control and completion detect.
  always_comb begin
    wd_en_s    = is_active(state_q);
    wd_clear_s = ~wd_en_s | encode_zero_flag_i;
    last_rev_s = (rev_num_q != '0) && ((rev_cnt_q + REV_ONE) == rev_num_q);
  end

  scan_wdog_cnt #(
    .TMO_W (TMO_W)
  ) u_wdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (wd_clear_s),
    .enable_i (wd_en_s),
    .limit_i  (tmo_q),
    .expire_o (wd_expire_s)
  );

  // Main FSM with registered outputs; branch order encodes event priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      start_dly_q   <= 1'b0;
      rev_num_q     <= '0;
      tmo_q         <= '0;
      acq_en_q      <= 1'b0;
      rev_start_q   <= 1'b0;
      rev_cnt_q     <= '0;
      test_mode_q   <= 1'b0;
      busy_q        <= 1'b0;
      scan_done_q   <= 1'b0;
      scan_abort_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      start_dly_q  <= scan_start_flag_i;
      rev_start_q  <= 1'b0;
      scan_done_q  <= 1'b0;
      scan_abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_edge_s) begin
            state_q     <= ST_WAIT_ZERO;
            busy_q      <= 1'b1;
            rev_num_q   <= cfg_rev_num_i;
            tmo_q       <= cfg_timeout_i;
            test_mode_q <= scan_test_flag_i;
          end
        end
        ST_WAIT_ZERO: begin
          if (!scan_start_flag_i) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            scan_abort_q <= 1'b1;
          end else if (wd_expire_s) begin
            state_q       <= ST_ERR;
            timeout_err_q <= 1'b1;
          end else if (encode_zero_flag_i) begin
            state_q     <= ST_ACQ;
            acq_en_q    <= 1'b1;
            rev_start_q <= 1'b1;
            rev_cnt_q   <= '0;
          end
        end
        ST_ACQ: begin
          if (!scan_start_flag_i) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            acq_en_q     <= 1'b0;
            scan_abort_q <= 1'b1;
          end else if (encode_zero_flag_i && last_rev_s) begin
            state_q     <= ST_DONE;
            acq_en_q    <= 1'b0;
            scan_done_q <= 1'b1;
          end else if (wd_expire_s) begin
            state_q       <= ST_ERR;
            acq_en_q      <= 1'b0;
            timeout_err_q <= 1'b1;
          end else if (encode_zero_flag_i) begin
            rev_cnt_q   <= rev_cnt_q + REV_ONE;
            rev_start_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!scan_start_flag_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_ERR: begin
          if (!scan_start_flag_i) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          acq_en_q      <= 1'b0;
          busy_q        <= 1'b0;
          timeout_err_q <= 1'b0;
        end
      endcase
    end
  end

  assign acq_en_o      = acq_en_q;
  assign rev_start_o   = rev_start_q;
  assign rev_cnt_o     = rev_cnt_q;
  assign test_mode_o   = test_mode_q;
  assign busy_o        = busy_q;
  assign scan_done_o   = scan_done_q;
  assign scan_abort_o  = scan_abort_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl: a cycle-by-cycle vector table plus
// hand-written sequences for multi-cycle scans, timeout, wrap and reset.
module tb_scan_seq_ctrl;

  // Narrow revolution counter keeps the wrap-around test short.
  localparam int RW = 8;
  localparam int TW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          zero = 1'b0;
  logic          start = 1'b0;
  logic          test = 1'b0;
  logic [RW-1:0] rn = '0;
  logic [TW-1:0] tmo = '0;

  logic          acq_en_o, rev_start_o, test_mode_o, busy_o;
  logic          scan_done_o, scan_abort_o, timeout_err_o;
  logic [RW-1:0] rev_cnt_o;

  int checks = 0;
  int errors = 0;

  int            rs_n, done_n, done_cyc, acq_n, err_at;
  logic [RW-1:0] seen [3];

  typedef struct {
    logic          s;
    logic          t;
    logic          z;
    logic [RW-1:0] rn;
    logic [6:0]    f;
    logic [RW-1:0] c;
  } vec_t;

  vec_t tbl [16];

  scan_seq_ctrl #(
    .REV_W (RW),
    .TMO_W (TW)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .encode_zero_flag_i (zero),
    .scan_start_flag_i  (start),
    .scan_test_flag_i   (test),
    .cfg_rev_num_i      (rn),
    .cfg_timeout_i      (tmo),
    .acq_en_o           (acq_en_o),
    .rev_start_o        (rev_start_o),
    .rev_cnt_o          (rev_cnt_o),
    .test_mode_o        (test_mode_o),
    .busy_o             (busy_o),
    .scan_done_o        (scan_done_o),
    .scan_abort_o       (scan_abort_o),
    .timeout_err_o      (timeout_err_o)
  );

  always #5 clk = ~clk;

  // Flags packed as {acq_en, rev_start, done, abort, timeout_err, busy, test_mode}.
  function automatic logic [6:0] flags();
    return {acq_en_o, rev_start_o, scan_done_o, scan_abort_o, timeout_err_o, busy_o, test_mode_o};
  endfunction

  function automatic vec_t mk(input logic s, input logic t, input logic z,
                              input logic [RW-1:0] r, input logic [6:0] f,
                              input logic [RW-1:0] c);
    vec_t v;
    v.s = s; v.t = t; v.z = z; v.rn = r; v.f = f; v.c = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL sim_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // rows: start, test, zero, rev_num -> flags, rev_cnt (timeout disabled)
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 8'd2, 7'b0000000, 8'd0);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 8'd2, 7'b0000011, 8'd0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b1, 8'd2, 7'b1100011, 8'd0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 8'd2, 7'b1000011, 8'd0);
    tbl[4]  = mk(1'b1, 1'b0, 1'b1, 8'd2, 7'b1100011, 8'd1);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 8'd9, 7'b1000011, 8'd1);
    tbl[6]  = mk(1'b1, 1'b0, 1'b1, 8'd9, 7'b0010011, 8'd1);
    tbl[7]  = mk(1'b1, 1'b0, 1'b1, 8'd9, 7'b0000011, 8'd1);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 8'd1, 7'b0000001, 8'd1);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 8'd1, 7'b0000001, 8'd1);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 8'd1, 7'b0000010, 8'd1);
    tbl[11] = mk(1'b1, 1'b0, 1'b1, 8'd1, 7'b1100010, 8'd0);
    tbl[12] = mk(1'b1, 1'b0, 1'b1, 8'd1, 7'b0010010, 8'd0);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 8'd1, 7'b0000000, 8'd0);
    tbl[14] = mk(1'b1, 1'b1, 1'b0, 8'd1, 7'b0000011, 8'd0);
    tbl[15] = mk(1'b0, 1'b1, 1'b0, 8'd1, 7'b0001001, 8'd0);

    repeat (2) tick();
    chk("reset_flags", {25'd0, flags()}, 32'd0);
    chk("reset_cnt", {24'd0, rev_cnt_o}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      start = tbl[i].s;
      test  = tbl[i].t;
      zero  = tbl[i].z;
      rn    = tbl[i].rn;
      tick();
      chk($sformatf("vec%0d_flags", i), {25'd0, flags()}, {25'd0, tbl[i].f});
      chk($sformatf("vec%0d_cnt", i), {24'd0, rev_cnt_o}, {24'd0, tbl[i].c});
    end
    start = 1'b0; test = 1'b0; zero = 1'b0;
    tick();

    // Three revolutions, zero pulse every 100 cycles.
    rn = 8'd3; tmo = '0; start = 1'b1;
    rs_n = 0; done_n = 0; done_cyc = -1; acq_n = 0;
    for (int c = 0; c < 500; c++) begin
      zero = (c % 100 == 50);
      tick();
      if (rev_start_o) begin
        if (rs_n < 3) seen[rs_n] = rev_cnt_o;
        rs_n++;
      end
      if (scan_done_o) begin
        done_n++;
        done_cyc = c;
      end
      if (acq_en_o) acq_n++;
    end
    zero = 1'b0;
    chk("rev3_rev_starts", rs_n, 32'd3);
    chk("rev3_cnt0", {24'd0, seen[0]}, 32'd0);
    chk("rev3_cnt1", {24'd0, seen[1]}, 32'd1);
    chk("rev3_cnt2", {24'd0, seen[2]}, 32'd2);
    chk("rev3_done_pulses", done_n, 32'd1);
    chk("rev3_done_cycle", done_cyc, 32'd350);
    chk("rev3_acq_cycles", acq_n, 32'd300);
    start = 1'b0;
    tick();
    chk("rev3_idle_busy", {31'd0, busy_o}, 32'd0);

    // Watchdog: one pulse, then silence.
    rn = 8'd5; tmo = 32'd50; start = 1'b1;
    tick();
    repeat (5) tick();
    zero = 1'b1;
    tick();
    zero = 1'b0;
    chk("tmo_acq_entered", {31'd0, acq_en_o}, 32'd1);
    err_at = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (timeout_err_o && err_at < 0) err_at = k;
    end
    chk("tmo_err_delay", err_at, 32'd50);
    chk("tmo_err_flags", {25'd0, flags()}, {25'd0, 7'b0000110});
    start = 1'b0;
    tick();
    chk("tmo_release_flags", {25'd0, flags()}, 32'd0);

    // Continuous mode wrap, then abort while a pulse is present.
    rn = '0; tmo = '0; start = 1'b1;
    tick();
    zero = 1'b1;
    tick();
    chk("wrap_first_cnt", {24'd0, rev_cnt_o}, 32'd0);
    chk("wrap_first_rs", {31'd0, rev_start_o}, 32'd1);
    repeat (255) tick();
    chk("wrap_max_cnt", {24'd0, rev_cnt_o}, 32'd255);
    tick();
    chk("wrap_zero_cnt", {24'd0, rev_cnt_o}, 32'd0);
    chk("wrap_zero_rs", {31'd0, rev_start_o}, 32'd1);
    repeat (10) tick();
    chk("wrap_cnt10", {24'd0, rev_cnt_o}, 32'd10);
    start = 1'b0;
    tick();
    chk("wrap_abort_flags", {25'd0, flags()}, {25'd0, 7'b0001000});
    tick();
    chk("wrap_abort_one_cycle", {31'd0, scan_abort_o}, 32'd0);
    zero = 1'b0;

    // Final pulse coincides with request withdrawal: abort wins.
    rn = 8'd2; start = 1'b1;
    tick();
    zero = 1'b1; tick(); zero = 1'b0; tick();
    zero = 1'b1; tick(); zero = 1'b0; tick();
    chk("race_cnt_before", {24'd0, rev_cnt_o}, 32'd1);
    zero = 1'b1; start = 1'b0;
    tick();
    zero = 1'b0;
    chk("race_flags", {25'd0, flags()}, {25'd0, 7'b0001000});
    tick();
    chk("race_no_late_done", {31'd0, scan_done_o}, 32'd0);

    // Test flag latched at start; asynchronous reset mid-acquisition.
    test = 1'b1; rn = 8'd4; start = 1'b1;
    tick();
    zero = 1'b1; tick(); zero = 1'b0;
    test = 1'b0;
    repeat (3) tick();
    chk("test_mode_held", {31'd0, test_mode_o}, 32'd1);
    zero = 1'b1; tick(); zero = 1'b0; tick();
    chk("rst_pre_acq", {31'd0, acq_en_o}, 32'd1);
    chk("rst_pre_cnt", {24'd0, rev_cnt_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_flags", {25'd0, flags()}, 32'd0);
    chk("rst_async_cnt", {24'd0, rev_cnt_o}, 32'd0);
    tick();
    chk("rst_held_flags", {25'd0, flags()}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_release_start", {25'd0, flags()}, {25'd0, 7'b0000010});
    start = 1'b0;
    tick();
    chk("rst_release_abort", {25'd0, flags()}, {25'd0, 7'b0001000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_seq_ctrl.md
SCAN_SEQ_CTRL -- requirements
Module: scan_seq_ctrl

Interface
REQ-001 Parameter TCQ, default 0.1, register clock-to-out delay for simulation.
REQ-002 Parameter REV_W, default 16, width of the revolution count.
REQ-003 Parameter TMO_W, default 32, width of the watchdog count.
REQ-004 clk_i  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 encode_zero_flag_i  input  1  one-cycle pulse per encoder zero crossing (one per revolution).
REQ-007 scan_start_flag_i  input  1  level; high = scan requested (begin or test).
REQ-008 scan_test_flag_i  input  1  level; high = test scan.
REQ-009 cfg_rev_num_i  input  REV_W  revolutions to acquire; 0 = continuous.
REQ-010 cfg_timeout_i  input  TMO_W  clk_i cycles allowed between zero pulses; 0 = watchdog disabled.
REQ-011 acq_en_o  output  1  level, high while acquiring.
REQ-012 rev_start_o  output  1  one-cycle pulse at the start of each acquired revolution.
REQ-013 rev_cnt_o  output  REV_W  index of the current revolution, starting at 0.
REQ-014 test_mode_o  output  1  scan_test_flag_i latched at scan start.
REQ-015 busy_o  output  1  high in every state except IDLE.
REQ-016 scan_done_o  output  1  one-cycle pulse on normal completion.
REQ-017 scan_abort_o  output  1  one-cycle pulse when the request is withdrawn during WAIT_ZERO or ACQ.
REQ-018 timeout_err_o  output  1  level, high while in ERR.

Function
REQ-019 FSM states SHALL be IDLE, WAIT_ZERO, ACQ, DONE and ERR; all outputs SHALL be registered.
REQ-020 Start SHALL be the rising edge of scan_start_flag_i, detected against a delay register that resets to 0 (a request already high when reset releases counts as a start).
REQ-021 IDLE + start -> WAIT_ZERO on that edge; latch cfg_rev_num_i, cfg_timeout_i and test_mode_o; clear the watchdog count.
REQ-022 WAIT_ZERO + zero pulse -> ACQ; on the same edge acq_en_o=1, rev_start_o=1, rev_cnt_o=0, watchdog cleared (output latency 1 cycle).
REQ-023 ACQ + zero pulse, latched rev_num!=0 and rev_cnt_o+1==rev_num -> DONE; on that edge acq_en_o=0 and scan_done_o=1.
REQ-024 ACQ + zero pulse otherwise -> rev_cnt_o increments (wraps at 2^REV_W-1 -> 0 in continuous mode), rev_start_o=1, watchdog cleared.
REQ-025 Latched rev_num==1 -> DONE on the first zero pulse after entering ACQ.
REQ-026 Watchdog SHALL count in WAIT_ZERO and ACQ when the latched timeout !=0; reaching the latched timeout -> ERR, acq_en_o=0, timeout_err_o=1.
REQ-027 scan_start_flag_i low in WAIT_ZERO or ACQ -> IDLE; acq_en_o=0, scan_abort_o=1, no scan_done_o.
REQ-028 Simultaneous events in one cycle: abort beats completion beats timeout beats zero-pulse increment.
REQ-029 DONE and ERR SHALL stay until scan_start_flag_i is low, then -> IDLE; no retrigger while the request stays high.
REQ-030 Changes on cfg_* or scan_test_flag_i after start SHALL have no effect until the next start.
REQ-031 Zero pulses in IDLE, DONE or ERR SHALL be ignored.

Reset
REQ-032 On reset: state IDLE; all outputs 0; rev_cnt_o 0; watchdog 0; all latched config 0; start edge register 0.
REQ-033 Reset asserted mid-scan SHALL force outputs low asynchronously and SHALL NOT generate scan_done_o or scan_abort_o.

Structure
REQ-034 Package scan_ctrl_pkg SHALL hold the state encoding and the default REV_W and TMO_W values.
REQ-035 The watchdog SHALL be the sub-module scan_wdog_cnt (clear, enable, limit, expire), so scan_seq_ctrl contains the FSM only.

Verification
REQ-036 rev_num=3, timeout=0; start, then zero pulses every 100 cycles -> rev_start_o x3 with rev_cnt_o 0,1,2; scan_done_o on the 4th pulse; acq_en_o high for 300 cycles.
REQ-037 rev_num=5, timeout=50; start, one zero pulse, none after -> ERR 50 cycles after that pulse, timeout_err_o=1; request low -> IDLE, busy_o=0.
REQ-038 rev_num=0; 70000 zero pulses -> rev_cnt_o wraps 65535 -> 0; request low -> scan_abort_o pulse, acq_en_o=0.
REQ-039 rev_num=2; final zero pulse and request fall in the same cycle -> scan_abort_o=1, scan_done_o stays 0.
REQ-040 Test flag high at start, dropped mid-scan -> test_mode_o stays 1 until the next start; reset mid-ACQ -> all outputs 0 immediately, no pulses.
